// File: rtl/otf_pkg.sv
// Shared types for the on-the-fly digit converter and the online-unit selection logic.
package otf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } digit_e;

  // QM starts one ulp below Q = 0, i.e. every bit set; replicated to the register width.
  localparam logic QM_RST_FILL = 1'b1;

endpackage

// File: rtl/bs_digit_decode.sv
// Borrow-save digit decode: (d_p, d_n) -> {+1, 0, -1}; both-set cancels to zero.
module bs_digit_decode
  import otf_pkg::*;
(
  input  logic       d_p,
  input  logic       d_n,
  output logic [1:0] digit
);

  digit_e dec;

  // Map the bit pair onto the decoded-digit enum.
  always_comb begin
    dec = ZERO;
    if (d_p && !d_n) begin
      dec = POS;
    end else if (!d_p && d_n) begin
      dec = NEG;
    end
  end

  assign digit = dec;

endmodule

// File: rtl/otf_digit_converter.sv
// Serial MSD-first on-the-fly conversion of borrow-save digits into an (N+1)-bit
// two's-complement fraction, using the Q / QM = Q-1 candidate pair so no carry ripples.
module otf_digit_converter
  import otf_pkg::*;
#(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic       d_p,
  input  logic       d_n,
  output logic       busy,
  output logic       out_valid,
  output logic [N:0] result
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0]  QM_INIT  = {W{QM_RST_FILL}};
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  qm_q, qm_d;
  logic [W-1:0]  result_q, result_d;
  logic          out_valid_q, out_valid_d;

  logic [1:0]    digit_raw;
  digit_e        digit;
  logic          accept;
  logic          done;
  logic [W-1:0]  q_base, qm_base;
  logic [CW-1:0] cnt_base, cnt_inc;

  bs_digit_decode u_decode (
    .d_p   (d_p),
    .d_n   (d_n),
    .digit (digit_raw)
  );

  assign digit = digit_e'(digit_raw);

  // Digit accept, candidate-register update and completion detect.
  always_comb begin
    accept   = in_valid && (start || (state_q == ACC));
    // A start digit discards any operand in flight and applies itself to fresh candidates.
    q_base   = start ? '0 : q_q;
    qm_base  = start ? QM_INIT : qm_q;
    cnt_base = start ? '0 : cnt_q;
    cnt_inc  = cnt_base + CW'(1);
    cnt_d    = cnt_q;
    q_d      = q_q;
    qm_d     = qm_q;
    done     = 1'b0;
    if (accept) begin
      cnt_d = cnt_inc;
      done  = (cnt_inc == CNT_LAST);
      unique case (digit)
        POS: begin
          q_d  = {q_base[W-2:0], 1'b1};
          qm_d = {q_base[W-2:0], 1'b0};
        end
        NEG: begin
          q_d  = {qm_base[W-2:0], 1'b1};
          qm_d = {qm_base[W-2:0], 1'b0};
        end
        default: begin
          q_d  = {q_base[W-2:0], 1'b0};
          qm_d = {qm_base[W-2:0], 1'b1};
        end
      endcase
    end
  end

  // Next state: the N-th digit ends the operand, any other accepted digit keeps accumulating.
  always_comb begin
    state_d = state_q;
    if (done) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = ACC;
    end
  end

  // State, digit counter and candidate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      qm_q    <= QM_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
    end
  end

  // Output stage inputs: result is only loaded on completion, otherwise held.
  always_comb begin
    out_valid_d = done;
    result_d    = done ? q_d : result_q;
  end

  // Registered outputs, so nothing combinational reaches result / out_valid from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // Moore outputs decoded from registers.
  always_comb begin
    busy      = (state_q == ACC);
    out_valid = out_valid_q;
    result    = result_q;
  end

endmodule
